// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared state encoding and defaults for the exec-stage hazard
//            controller and its helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Sequencer states
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_MC_RUN  = 2'd1;
    localparam logic [1:0] c_MC_DONE = 2'd2;

    // Default multi-cycle latency and register index width
    localparam int c_MC_LAT_DEF = 8;
    localparam int c_REG_W_DEF  = 5;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/exec_hazard_controller_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Combinational load-use comparator. Flags when the load sitting in
//            ID/EX writes a register that the IF/ID instruction reads.
//            Register 0 is hard-wired zero and never creates a hazard.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_idex_mem_read,
    input  logic [REG_W-1:0] i_idex_rt,
    input  logic [REG_W-1:0] i_ifid_rs,
    input  logic [REG_W-1:0] i_ifid_rt,
    input  logic             i_ifid_uses_rt,
    output logic             o_hazard
);

    logic w_rt_nonzero;
    logic w_rs_match;
    logic w_rt_match;

    assign w_rt_nonzero = (i_idex_rt != '0);
    assign w_rs_match   = (i_idex_rt == i_ifid_rs);
    assign w_rt_match   = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);

    assign o_hazard = i_idex_mem_read && w_rt_nonzero && (w_rs_match || w_rt_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/exec_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : exec_hazard_controller
// Brief    : Exec-stage pipeline sequencer. Produces PC / IF/ID / ID/EX /
//            EX/MEM stall, hold, bubble and flush controls for load-use
//            hazards, taken branches and multi-cycle ALU operations.
// Revision : 1.0 - initial release
// ============================================================================
module exec_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W  = c_REG_W_DEF,
    parameter int MC_LAT = c_MC_LAT_DEF,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_memRead,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_usesRt,
    input  logic             idex_multiCycle,
    input  logic             pcSrc,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             idexHold,
    output logic             exmemBubble,
    output logic             aluIterate,
    output logic             mcDone
);

    // The IDLE cycle that launches an op already performs the first
    // iteration and MC_DONE is the last cycle, so MC_RUN lasts MC_LAT-2.
    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(MC_LAT - 2);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_hazard;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .i_idex_mem_read (idex_memRead),
        .i_idex_rt       (idex_rt),
        .i_ifid_rs       (ifid_rs),
        .i_ifid_rt       (ifid_rt),
        .i_ifid_uses_rt  (ifid_usesRt),
        .o_hazard        (w_hazard)
    );

    // Next-state and counter logic; the count is the number of MC_RUN cycles left.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            c_IDLE: begin
                if (idex_multiCycle) begin
                    // A two-cycle op has no MC_RUN phase at all.
                    if (c_CNT_INIT == '0) begin
                        w_state_nxt = c_MC_DONE;
                    end else begin
                        w_state_nxt = c_MC_RUN;
                        w_count_nxt = c_CNT_INIT;
                    end
                end
            end
            c_MC_RUN: begin
                if (r_count != '0) begin
                    w_count_nxt = r_count - 1'b1;
                end
                if (r_count <= CNT_W'(1)) begin
                    w_state_nxt = c_MC_DONE;
                end
            end
            c_MC_DONE: w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // State and counter registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Output decode; reset forces the free-running values regardless of inputs.
    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexBubble  = 1'b0;
        idexHold    = 1'b0;
        exmemBubble = 1'b0;
        aluIterate  = 1'b0;
        mcDone      = 1'b0;
        if (reset) begin
            if ((r_state == c_MC_RUN) || ((r_state == c_IDLE) && idex_multiCycle)) begin
                // Multi-cycle hold wins over any load flag in the same ID/EX slot.
                pcWrite     = 1'b0;
                ifidWrite   = 1'b0;
                idexHold    = 1'b1;
                exmemBubble = 1'b1;
                aluIterate  = 1'b1;
            end else if ((r_state == c_IDLE) || (r_state == c_MC_DONE)) begin
                mcDone = (r_state == c_MC_DONE);
                if (pcSrc) begin
                    // Taken branch squashes the younger instructions, so any
                    // load-use stall against them is moot.
                    ifidFlush  = 1'b1;
                    idexBubble = 1'b1;
                end else if (w_hazard) begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexBubble = 1'b1;
                end
            end
        end
    end

    // A branch can never be resolving while a multi-cycle op owns exec.
    a_no_branch_in_mc_run : assert property (
        @(posedge clk) disable iff (!reset) !(pcSrc && (r_state == c_MC_RUN))
    );

endmodule : exec_hazard_controller
`default_nettype wire

// File: tb/tb_exec_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_hazard_controller
// Brief    : Directed bench for exec_hazard_controller with a scoreboard of
//            expected output vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_hazard_controller;

    localparam int REG_W = 5;

    // Output vector order: {pcWrite, ifidWrite, ifidFlush, idexBubble,
    //                       idexHold, exmemBubble, aluIterate, mcDone}
    localparam logic [7:0] E_NORM = 8'b1100_0000;
    localparam logic [7:0] E_LU   = 8'b0001_0000;
    localparam logic [7:0] E_BR   = 8'b1111_0000;
    localparam logic [7:0] E_RUN  = 8'b0000_1110;
    localparam logic [7:0] E_DONE = 8'b1100_0001;

    logic             clk = 1'b0;
    logic             reset;
    logic             idex_memRead;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_usesRt;
    logic             idex_multiCycle;
    logic             pcSrc;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             idexBubble;
    logic             idexHold;
    logic             exmemBubble;
    logic             aluIterate;
    logic             mcDone;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_exp[$];
    string      q_tag[$];

    exec_hazard_controller #(
        .REG_W  (REG_W),
        .MC_LAT (8),
        .CNT_W  (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .idex_memRead    (idex_memRead),
        .idex_rt         (idex_rt),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .ifid_usesRt     (ifid_usesRt),
        .idex_multiCycle (idex_multiCycle),
        .pcSrc           (pcSrc),
        .pcWrite         (pcWrite),
        .ifidWrite       (ifidWrite),
        .ifidFlush       (ifidFlush),
        .idexBubble      (idexBubble),
        .idexHold        (idexHold),
        .exmemBubble     (exmemBubble),
        .aluIterate      (aluIterate),
        .mcDone          (mcDone)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [7:0] exp, input string tag);
        q_exp.push_back(exp);
        q_tag.push_back(tag);
    endtask

    task automatic compare_head();
        logic [7:0] got;
        logic [7:0] exp;
        string      tag;
        exp = q_exp.pop_front();
        tag = q_tag.pop_front();
        got = {pcWrite, ifidWrite, ifidFlush, idexBubble,
               idexHold, exmemBubble, aluIterate, mcDone};
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One pipeline cycle: inputs already driven just after the rising edge,
    // outputs sampled on the falling edge, then move to just past the next rise.
    task automatic step(input logic [7:0] exp, input string tag);
        push_exp(exp, tag);
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input logic [1:0] exp, input string tag);
        n_tests++;
        assert (dut.r_state === exp) else begin
            n_fail++;
            $error("FAIL %s: observed state %0d expected %0d", tag, dut.r_state, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b0;
        idex_memRead    = 1'b0;
        idex_rt         = '0;
        ifid_rs         = '0;
        ifid_rt         = '0;
        ifid_usesRt     = 1'b0;
        idex_multiCycle = 1'b1;
        pcSrc           = 1'b0;

        // Reset held with a pending multi-cycle op: outputs stay free-running
        for (int i = 0; i < 3; i++) step(E_NORM, "reset_hold");
        check_state(2'd0, "reset_state");

        idex_multiCycle = 1'b0;
        reset           = 1'b1;
        step(E_NORM, "idle");

        // Load-use on rs: one stall cycle, then ID/EX holds the bubble
        idex_memRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        step(E_LU, "lu_rs_stall");
        idex_memRead = 1'b0;
        step(E_NORM, "lu_rs_after");

        // Register 0 is never a hazard
        idex_memRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        step(E_NORM, "lu_r0");

        // rt match only counts when the IF/ID instruction reads rt
        idex_rt = 5'd9; ifid_rs = 5'd1; ifid_rt = 5'd9; ifid_usesRt = 1'b0;
        step(E_NORM, "lu_rt_unused");
        ifid_usesRt = 1'b1;
        step(E_LU, "lu_rt_stall");
        idex_memRead = 1'b0;
        step(E_NORM, "lu_rt_after");

        // Plain taken branch
        pcSrc = 1'b1;
        step(E_BR, "branch");
        pcSrc = 1'b0;

        // Branch beats a simultaneous load-use hazard
        pcSrc = 1'b1; idex_memRead = 1'b1; idex_rt = 5'd3; ifid_rt = 5'd3;
        ifid_rs = 5'd7; ifid_usesRt = 1'b1;
        step(E_BR, "branch_over_lu");
        pcSrc = 1'b0; idex_memRead = 1'b0; ifid_usesRt = 1'b0;
        step(E_NORM, "branch_after");

        // Single multi-cycle op, MC_LAT = 8
        idex_multiCycle = 1'b1;
        for (int i = 1; i <= 7; i++) step(E_RUN, "mc_run");
        step(E_DONE, "mc_done");
        idex_multiCycle = 1'b0;
        step(E_NORM, "mc_after");

        // Back-to-back multi-cycle ops
        idex_multiCycle = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 8 || i == 16) step(E_DONE, "b2b_done");
            else                   step(E_RUN,  "b2b_run");
        end
        idex_multiCycle = 1'b0;
        step(E_NORM, "b2b_after");

        // Reset asserted in the third cycle of an op
        idex_multiCycle = 1'b1;
        for (int i = 1; i <= 2; i++) step(E_RUN, "rst_pre_run");
        #2;
        reset = 1'b0;
        #1;
        push_exp(E_NORM, "rst_async");
        compare_head();
        check_state(2'd0, "rst_async_state");
        idex_multiCycle = 1'b0;
        @(posedge clk);
        #1;
        step(E_NORM, "rst_mid_hold");
        reset = 1'b1;
        step(E_NORM, "rst_release");

        // The next op after release takes the full latency
        idex_multiCycle = 1'b1;
        for (int i = 1; i <= 7; i++) step(E_RUN, "post_rst_run");
        step(E_DONE, "post_rst_done");
        idex_multiCycle = 1'b0;
        step(E_NORM, "post_rst_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_exec_hazard_controller
`default_nettype wire
